// File: rtl/gtfraw_stats_pkg.sv
// Shared constants for the pm_tick statistics bank.
// Holds read-port and sequence widths plus the pm_tick pipeline latencies,
// so the bank and any consumer agree on them.
package gtfraw_stats_pkg;

   // Channel index width on the read port (covers up to 32 channels).
   localparam int RDCH_W = 5;

   // Snapshot sequence number width; wraps modulo 2^SEQ_W.
   localparam int SEQ_W = 16;

   // pm_tick pipeline: stage 0 = pm_tick_r (counter restart / capture),
   // stage 1 = pm_tick_d1 (statshold load), stage 2 = snap_valid.
   localparam int TICK_STAGES = 3;
   localparam int TICK_R_STG  = 0;
   localparam int TICK_D1_STG = 1;
   localparam int SNAP_STG    = 2;

endpackage

// File: rtl/gtfraw_pmtick_chcnt.sv
// One statistics channel: split LSB/MSB interval counter, per-interval
// overflow flag, interval capture and statshold register.
// Optional feature: define PMTICK_STATSBANK_SATURATE_EN to saturate the
// counter at all-ones after overflow; otherwise it wraps. The ovf flag is
// sticky for the interval in both builds.
module gtfraw_pmtick_chcnt #(
   parameter int INWIDTH  = 16,
   parameter int OUTWIDTH = 48
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pm_tick_r,
   input  logic                pm_tick_d1,
   input  logic [INWIDTH-1:0]  pulsein,
   output logic [OUTWIDTH-1:0] statshold,
   output logic                hold_ovf
);

   localparam int HW = OUTWIDTH / 2;
   localparam int SW = HW + 1;

   logic [HW-1:0] lsb_q;
   logic [HW-1:0] msb_q;
   logic          carry_q;
   logic          ovf_q;
   logic [HW-1:0] cap_lsb_q;
   logic [HW-1:0] cap_msb_q;
   logic          cap_ovf_q;
   logic [SW-1:0] lsb_sum;
   logic [SW-1:0] msb_sum;
   logic          ovf_now;

   // Half-width adders; the MSB add consumes the carry registered last cycle.
   always_comb begin
      lsb_sum = {1'b0, lsb_q} + SW'(pulsein);
      msb_sum = {1'b0, msb_q} + SW'(carry_q);
      ovf_now = ovf_q | msb_sum[HW];
   end

   // Interval counter: on pm_tick_r close the interval (folding in the
   // pending carry) and restart with this cycle's increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lsb_q     <= '0;
         msb_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         cap_lsb_q <= '0;
         cap_msb_q <= '0;
         cap_ovf_q <= 1'b0;
      end else if (pm_tick_r) begin
`ifdef PMTICK_STATSBANK_SATURATE_EN
         cap_lsb_q <= ovf_now ? '1 : lsb_q;
         cap_msb_q <= ovf_now ? '1 : msb_sum[HW-1:0];
`else
         cap_lsb_q <= lsb_q;
         cap_msb_q <= msb_sum[HW-1:0];
`endif
         cap_ovf_q <= ovf_now;
         lsb_q     <= HW'(pulsein);
         msb_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
`ifdef PMTICK_STATSBANK_SATURATE_EN
         if (ovf_now) begin
            lsb_q   <= '1;
            msb_q   <= '1;
            carry_q <= 1'b0;
         end else begin
            lsb_q   <= lsb_sum[HW-1:0];
            carry_q <= lsb_sum[HW];
            msb_q   <= msb_sum[HW-1:0];
         end
`else
         lsb_q   <= lsb_sum[HW-1:0];
         carry_q <= lsb_sum[HW];
         msb_q   <= msb_sum[HW-1:0];
`endif
         ovf_q <= ovf_now;
      end
   end

   // statshold takes the closed interval one cycle after capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         statshold <= '0;
         hold_ovf  <= 1'b0;
      end else if (pm_tick_d1) begin
         statshold <= {cap_msb_q, cap_lsb_q};
         hold_ovf  <= cap_ovf_q;
      end
   end

endmodule

// File: rtl/gtfraw_wrapper_pmtick_statsbank.sv
// pm_tick statistics bank: NUM_CH interval counters snapshotted on each
// pm_tick into statshold, mirrored into a read-visible bank (statsout) that
// hold_output can freeze, with a registered single-channel read port.
// Optional feature: PMTICK_STATSBANK_SATURATE_EN (saturating counters).
module gtfraw_wrapper_pmtick_statsbank
   import gtfraw_stats_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int INWIDTH  = 16,
   parameter int OUTWIDTH = 48
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pm_tick,
   input  logic [NUM_CH*INWIDTH-1:0] pulsein,
   input  logic                      hold_output,
   input  logic                      rd_en,
   input  logic [RDCH_W-1:0]         rd_ch,
   output logic                      rd_valid,
   output logic [OUTWIDTH-1:0]       rd_data,
   output logic                      rd_ovf,
   output logic                      rd_err,
   output logic                      snap_valid,
   output logic [SEQ_W-1:0]          snap_seq
);

   logic [TICK_STAGES-1:0]           tick_pipe;
   logic                             pm_tick_r;
   logic                             pm_tick_d1;
   logic [NUM_CH-1:0][OUTWIDTH-1:0]  statshold;
   logic [NUM_CH-1:0]                hold_ovf;
   logic [NUM_CH-1:0][OUTWIDTH-1:0]  statsout;
   logic [NUM_CH-1:0]                statsout_ovf;
   logic [OUTWIDTH-1:0]              sel_data;
   logic                             sel_ovf;
   logic                             sel_hit;

   assign pm_tick_r  = tick_pipe[TICK_R_STG];
   assign pm_tick_d1 = tick_pipe[TICK_D1_STG];
   assign snap_valid = tick_pipe[SNAP_STG];

   // pm_tick delay line; the last stage is the snap_valid pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tick_pipe <= '0;
      else       tick_pipe <= {tick_pipe[TICK_STAGES-2:0], pm_tick};
   end

   // Sequence number advances on the same edge that raises snap_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           snap_seq <= '0;
      else if (pm_tick_d1) snap_seq <= snap_seq + 1'b1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      gtfraw_pmtick_chcnt #(
         .INWIDTH  (INWIDTH),
         .OUTWIDTH (OUTWIDTH)
      ) u_chcnt (
         .clk        (clk),
         .reset      (reset),
         .pm_tick_r  (pm_tick_r),
         .pm_tick_d1 (pm_tick_d1),
         .pulsein    (pulsein[c*INWIDTH +: INWIDTH]),
         .statshold  (statshold[c]),
         .hold_ovf   (hold_ovf[c])
      );
   end

   // Read-visible bank follows statshold unless frozen by hold_output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         statsout     <= '0;
         statsout_ovf <= '0;
      end else if (!hold_output) begin
         statsout     <= statshold;
         statsout_ovf <= hold_ovf;
      end
   end

   // Channel select; an index with no matching channel yields zeros.
   always_comb begin
      sel_data = '0;
      sel_ovf  = 1'b0;
      sel_hit  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == RDCH_W'(c)) begin
            sel_data = statsout[c];
            sel_ovf  = statsout_ovf[c];
            sel_hit  = 1'b1;
         end
      end
   end

   // Registered read: samples statsout before any same-edge bank update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_ovf   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= sel_data;
            rd_ovf  <= sel_ovf;
            rd_err  <= ~sel_hit;
         end
      end
   end

endmodule

// File: doc/gtfraw_wrapper_pmtick_statsbank.md
GTFRAW_WRAPPER_PMTICK_STATSBANK -- requirements
Module: gtfraw_wrapper_pmtick_statsbank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent statistics channels, 1..32.
REQ-002 SHALL have parameter INWIDTH, default 16: width of each channel's per-cycle increment.
REQ-003 SHALL have parameter OUTWIDTH, default 48: counter and snapshot width; even; OUTWIDTH/2 > INWIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pm_tick, input, 1 bit: interval boundary pulse shared by all channels.
REQ-007 SHALL have port pulsein, input, NUM_CH*INWIDTH bits: channel c increment in bits [c*INWIDTH +: INWIDTH].
REQ-008 SHALL have port hold_output, input, 1 bit: while high, the read-visible snapshot bank is frozen.
REQ-009 SHALL have port rd_en, input, 1 bit: read request.
REQ-010 SHALL have port rd_ch, input, 5 bits: channel index to read.
REQ-011 SHALL have port rd_valid, output, 1 bit: read data qualifier.
REQ-012 SHALL have port rd_data, output, OUTWIDTH bits: snapshot value of the channel read.
REQ-013 SHALL have port rd_ovf, output, 1 bit: the channel read saturated or wrapped in its interval.
REQ-014 SHALL have port rd_err, output, 1 bit: rd_ch >= NUM_CH.
REQ-015 SHALL have port snap_valid, output, 1 bit: one-cycle pulse on each new snapshot.
REQ-016 SHALL have port snap_seq, output, 16 bits: snapshot sequence number.

Function
REQ-017 SHALL register pm_tick once to form pm_tick_r, then again to form pm_tick_d1.
REQ-018 SHALL treat pulsein in the cycle pm_tick_r is high as the first increment of the new interval.
REQ-019 SHALL split each counter into LSB and MSB halves of OUTWIDTH/2, with the LSB carry registered into the MSB one cycle later.
REQ-020 SHALL, with pm_tick high in cycle 0, load per-channel statshold at the end of cycle 2 and assert snap_valid in cycle 3.
REQ-021 SHALL copy statshold into the read-visible bank statsout each cycle hold_output is low, and keep statsout unchanged while it is high.
REQ-022 SHALL, when rd_en is high in cycle k, present rd_data, rd_ovf and rd_err from the cycle-k statsout with rd_valid high in cycle k+1; rd_valid SHALL be low otherwise.
REQ-023 SHALL, for an out-of-range rd_ch, return rd_data=0, rd_ovf=0 and rd_err=1.
REQ-024 SHALL increment snap_seq modulo 2^16 in the cycle snap_valid asserts.
REQ-025 SHALL, on back-to-back pm_tick (cycles 0 and 1), produce two snapshots, the second holding only the single cycle-1 pulsein value.
REQ-026 SHALL, when a read and a statsout update coincide at the same edge, return the pre-update value.

Reset
REQ-027 SHALL clear all counters, overflow flags, statshold, statsout, pm_tick pipeline, snap_seq, rd_* outputs and snap_valid to 0 asynchronously while reset is high.
REQ-028 SHALL, when reset is asserted mid-interval, discard that interval; the first snapshot SHALL count from reset deassertion.

Configuration
REQ-029 SHALL, with macro PMTICK_STATSBANK_SATURATE_EN defined, hold a counter at all-ones after overflow until the next boundary and set its ovf flag.
REQ-030 SHALL, without PMTICK_STATSBANK_SATURATE_EN, let the counter wrap modulo 2^OUTWIDTH while still setting the sticky per-interval ovf flag.

Structure
REQ-031 SHALL place the snap_seq width, the rd_ch width and the pipeline-latency constants in the shared package gtfraw_stats_pkg.
REQ-032 SHALL implement each channel's split counter and statshold in sub-module gtfraw_pmtick_chcnt, instantiated NUM_CH times.

Verification
REQ-033 SHALL verify: ch0 pulsein=3 for 100 cycles, then pm_tick -> after hold_output low, a read of ch0 returns 300 with rd_ovf=0 and snap_seq=1.
REQ-034 SHALL verify: with OUTWIDTH=16 and ch1 pulsein=255 for 300 cycles -> 0xFFFF with rd_ovf=1 when saturating, or 76500 mod 65536 = 0x2AD4 with rd_ovf=1 when wrapping.
REQ-035 SHALL verify: LSB carry path: counter preloaded to 0x00FF via pulses, +1 -> 0x0100 in the snapshot.
REQ-036 SHALL verify: hold_output high across a pm_tick -> reads still return the old value, and the new value appears one cycle after hold_output falls.
REQ-037 SHALL verify: rd_ch=NUM_CH -> rd_valid=1, rd_err=1, rd_data=0 on the next cycle.
REQ-038 SHALL verify: reset pulsed mid-interval, then 10 pulses and pm_tick -> snapshot=10, snap_seq=1.
